hist_range_tracker: RTL and testbench



---
 rtl/hist_pkg.sv | 13 +
 rtl/hist_iir_step.sv | 31 +++
 rtl/hist_range_tracker.sv | 142 ++++++++++++++
 tb/tb_hist_range_tracker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared definitions for the histogram range tracker and the 14-to-8 bit scaler.
package hist_pkg;

    localparam int PIX_W  = 14;
    localparam int COEF_W = 18;
    localparam logic [PIX_W-1:0] PIX_MAX = 14'h3FFF;

    typedef enum logic {
        ACCUM = 1'b0,
        LATCH = 1'b1
    } hist_state_e;

endpackage

// File: rtl/hist_iir_step.sv
// One coefficient's low-pass update toward a new target, clamped to a floor.
// Only instantiated when HIST_RANGE_IIR_EN is defined.
module hist_iir_step
    import hist_pkg::*;
#(
    parameter int SHIFT   = 3,
    parameter int MIN_VAL = 0
) (
    input  logic [PIX_W-1:0] cur,
    input  logic [PIX_W-1:0] target,
    output logic [PIX_W-1:0] result
);

    localparam logic signed [18:0] MIN_S = 19'(MIN_VAL);

    logic signed [18:0] diff;
    logic signed [18:0] step;
    logic signed [18:0] sum;
    logic [4:0]         sum_unused_hi;

    // The sum always lies between cur and target, so it fits back into 14 bits.
    always_comb begin
        diff   = $signed({5'b0, target}) - $signed({5'b0, cur});
        step   = diff >>> SHIFT;
        sum    = $signed({5'b0, cur}) + step;
        result = (sum < MIN_S) ? MIN_S[PIX_W-1:0] : sum[PIX_W-1:0];
    end

    assign sum_unused_hi = sum[18:14];

endmodule

// File: rtl/hist_range_tracker.sv
// Tracks per-frame pixel min/max and publishes add/div coefficients for the scaler.
// Optional smoothing of the published values is enabled with HIST_RANGE_IIR_EN.
module hist_range_tracker
    import hist_pkg::*;
#(
    parameter int MIN_SPAN    = 64,
    parameter int DEFAULT_DIV = 16383,
    parameter int IIR_SHIFT   = 3
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [PIX_W-1:0]  din,
    input  logic              din_valid,
    output logic              din_rdy,
    input  logic              din_last,
    output logic [COEF_W-1:0] add,
    output logic [COEF_W-1:0] div,
    output logic              range_valid,
    output logic [15:0]       frame_cnt,
    output logic              dbg_state
);

    localparam logic [PIX_W-1:0] MIN_SPAN_W    = PIX_W'(MIN_SPAN);
    localparam logic [PIX_W-1:0] DEFAULT_DIV_W = PIX_W'(DEFAULT_DIV);

    // Handshake: a pixel (and its din_last) is consumed on a rising edge where
    // din_valid and din_rdy are both high; din_rdy does not depend on din_valid.
    hist_state_e      state_q, state_d;
    logic [PIX_W-1:0] min_q, min_d;
    logic [PIX_W-1:0] max_q, max_d;
    logic [PIX_W-1:0] add_q, add_d;
    logic [PIX_W-1:0] div_q, div_d;
    logic             range_valid_q, range_valid_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             din_rdy_q, din_rdy_d;

    logic             accept;
    logic [PIX_W-1:0] span_raw;
    logic [PIX_W-1:0] span;
    logic [PIX_W-1:0] pub_add;
    logic [PIX_W-1:0] pub_div;

    assign accept   = din_valid & din_rdy_q;
    assign span_raw = max_q - min_q;
    assign span     = (span_raw < MIN_SPAN_W) ? MIN_SPAN_W : span_raw;

`ifdef HIST_RANGE_IIR_EN
    logic             primed_q, primed_d;
    logic [PIX_W-1:0] iir_add;
    logic [PIX_W-1:0] iir_div;

    hist_iir_step #(.SHIFT(IIR_SHIFT), .MIN_VAL(0)) u_iir_add (
        .cur    (add_q),
        .target (min_q),
        .result (iir_add)
    );

    hist_iir_step #(.SHIFT(IIR_SHIFT), .MIN_VAL(MIN_SPAN)) u_iir_div (
        .cur    (div_q),
        .target (span),
        .result (iir_div)
    );

    // The first frame after reset has no history to blend with.
    assign pub_add  = primed_q ? iir_add : min_q;
    assign pub_div  = primed_q ? iir_div : span;
    assign primed_d = primed_q | (state_q == LATCH);

    always_ff @(posedge clk) begin
        if (srst) primed_q <= 1'b0;
        else      primed_q <= primed_d;
    end
`else
    assign pub_add = min_q;
    assign pub_div = span;
`endif

    always_comb begin
        state_d       = state_q;
        min_d         = min_q;
        max_d         = max_q;
        add_d         = add_q;
        div_d         = div_q;
        range_valid_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        din_rdy_d     = din_rdy_q;
        case (state_q)
            ACCUM: begin
                din_rdy_d = 1'b1;
                if (accept) begin
                    min_d = (din < min_q) ? din : min_q;
                    max_d = (din > max_q) ? din : max_q;
                    if (din_last) begin
                        state_d   = LATCH;
                        din_rdy_d = 1'b0;
                    end
                end
            end
            LATCH: begin
                add_d         = pub_add;
                div_d         = pub_div;
                range_valid_d = 1'b1;
                frame_cnt_d   = frame_cnt_q + 16'd1;
                min_d         = PIX_MAX;
                max_d         = '0;
                state_d       = ACCUM;
                din_rdy_d     = 1'b1;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q       <= ACCUM;
            min_q         <= PIX_MAX;
            max_q         <= '0;
            add_q         <= '0;
            div_q         <= DEFAULT_DIV_W;
            range_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
            din_rdy_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            min_q         <= min_d;
            max_q         <= max_d;
            add_q         <= add_d;
            div_q         <= div_d;
            range_valid_q <= range_valid_d;
            frame_cnt_q   <= frame_cnt_d;
            din_rdy_q     <= din_rdy_d;
        end
    end

    assign din_rdy     = din_rdy_q;
    assign add         = {4'h0, add_q};
    assign div         = {4'h0, div_q};
    assign range_valid = range_valid_q;
    assign frame_cnt   = frame_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_hist_range_tracker.sv
// Directed bench for hist_range_tracker; build with HIST_RANGE_IIR_EN to cover smoothing.
module tb_hist_range_tracker;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic [13:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_rdy;
    logic        din_last = 1'b0;
    logic [17:0] add;
    logic [17:0] div;
    logic        range_valid;
    logic [15:0] frame_cnt;
    logic        dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    // Observations around the end of a frame (cycles N+1, N+2, N+3).
    logic        obs_rdy1, obs_rv1, obs_rv2, obs_rdy2, obs_rv3;
    logic [17:0] obs_add, obs_div;
    logic [15:0] obs_fc;

    always #5 clk = ~clk;

    hist_range_tracker dut (
        .clk         (clk),
        .srst        (srst),
        .din         (din),
        .din_valid   (din_valid),
        .din_rdy     (din_rdy),
        .din_last    (din_last),
        .add         (add),
        .div         (div),
        .range_valid (range_valid),
        .frame_cnt   (frame_cnt),
        .dbg_state   (dbg_state)
    );

    // Expected published value for a frame that is not the first after reset.
    function automatic int exp_pub(input int prev, input int target, input int floor_v);
`ifdef HIST_RANGE_IIR_EN
        int s;
        s = prev + ((target - prev) >>> 3);
        return (s < floor_v) ? floor_v : s;
`else
        return target;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        srst = 1'b1; din_valid = 1'b0; din_last = 1'b0;
        repeat (2) @(negedge clk);
        srst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_pix(input int v, input logic last);
        int w;
        @(negedge clk);
        w = 0;
        while (!din_rdy && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (w == 8) begin
            tests_run++; tests_failed++;
            $display("FAIL din_rdy_timeout: din_rdy=%0b required 1", din_rdy);
        end
        din = 14'(v); din_valid = 1'b1; din_last = last;
    endtask

    task automatic send_ramp(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) send_pix(v, v == hi);
    endtask

    task automatic observe_frame_end();
        @(negedge clk);
        din_valid = 1'b0; din_last = 1'b0;
        obs_rdy1 = din_rdy; obs_rv1 = range_valid;
        @(negedge clk);
        obs_rv2 = range_valid; obs_rdy2 = din_rdy;
        obs_add = add; obs_div = div; obs_fc = frame_cnt;
        @(negedge clk);
        obs_rv3 = range_valid;
    endtask

    task automatic test_reset();
        @(negedge clk);
        srst = 1'b1; din_valid = 1'b0; din_last = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (add !== 18'd0 || div !== 18'd16383 || range_valid !== 1'b0 || frame_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_values: add=%0d div=%0d rv=%0b fc=%0d required 0 16383 0 0",
                     add, div, range_valid, frame_cnt);
        end
        tests_run++;
        if (din_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rdy_low: din_rdy=%0b required 0", din_rdy);
        end
        srst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (din_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_rdy_rise: din_rdy=%0b required 1", din_rdy);
        end
    endtask

    task automatic test_ramp();
        do_reset();
        send_ramp(1000, 3000);
        observe_frame_end();
        tests_run++;
        if (obs_add !== 18'd1000 || obs_div !== 18'd2000 || obs_fc !== 16'd1) begin
            tests_failed++;
            $display("FAIL ramp_coef: add=%0d div=%0d fc=%0d required 1000 2000 1", obs_add, obs_div, obs_fc);
        end
        tests_run++;
        if (obs_rv1 !== 1'b0 || obs_rv2 !== 1'b1 || obs_rv3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL ramp_pulse: rv(N+1,N+2,N+3)=%0b%0b%0b required 010", obs_rv1, obs_rv2, obs_rv3);
        end
        tests_run++;
        if (obs_rdy1 !== 1'b0 || obs_rdy2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL ramp_rdy: rdy(N+1,N+2)=%0b%0b required 01", obs_rdy1, obs_rdy2);
        end
        tests_run++;
        if (add !== 18'd1000 || div !== 18'd2000) begin
            tests_failed++;
            $display("FAIL ramp_hold: add=%0d div=%0d required 1000 2000", add, div);
        end
    endtask

    task automatic test_flat();
        do_reset();
        for (int i = 0; i < 8; i++) send_pix(5000, i == 7);
        observe_frame_end();
        tests_run++;
        if (obs_add !== 18'd5000 || obs_div !== 18'd64 || obs_rv2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL flat_coef: add=%0d div=%0d rv=%0b required 5000 64 1", obs_add, obs_div, obs_rv2);
        end
        send_pix(0, 1'b1);
        observe_frame_end();
        tests_run++;
        if (obs_add !== 18'(exp_pub(5000, 0, 0)) || obs_div !== 18'(exp_pub(64, 64, 64)) || obs_fc !== 16'd2) begin
            tests_failed++;
            $display("FAIL single_pixel: add=%0d div=%0d fc=%0d required %0d %0d 2",
                     obs_add, obs_div, obs_fc, exp_pub(5000, 0, 0), exp_pub(64, 64, 64));
        end
    endtask

    task automatic test_extremes();
        do_reset();
        send_pix(5000, 1'b0);
        send_pix(0, 1'b0);
        send_pix(16383, 1'b0);
        send_pix(7, 1'b1);
        observe_frame_end();
        tests_run++;
        if (obs_add !== 18'd0 || obs_div !== 18'd16383) begin
            tests_failed++;
            $display("FAIL extremes: add=%0d div=%0d required 0 16383", obs_add, obs_div);
        end
        send_ramp(200, 300);
        observe_frame_end();
        tests_run++;
        if (obs_add !== 18'(exp_pub(0, 200, 0)) || obs_div !== 18'(exp_pub(16383, 100, 64)) || obs_fc !== 16'd2) begin
            tests_failed++;
            $display("FAIL stats_reset: add=%0d div=%0d fc=%0d required %0d %0d 2",
                     obs_add, obs_div, obs_fc, exp_pub(0, 200, 0), exp_pub(16383, 100, 64));
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int v = 10; v <= 20; v++) send_pix(v, 1'b0);
        do_reset();
        send_ramp(500, 600);
        observe_frame_end();
        tests_run++;
        if (obs_add !== 18'd500 || obs_div !== 18'd100 || obs_fc !== 16'd1) begin
            tests_failed++;
            $display("FAIL reset_mid_frame: add=%0d div=%0d fc=%0d required 500 100 1", obs_add, obs_div, obs_fc);
        end
    endtask

    task automatic test_reset_in_latch();
        do_reset();
        send_pix(42, 1'b1);
        @(negedge clk);
        din_valid = 1'b0; din_last = 1'b0; srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        tests_run++;
        if (range_valid !== 1'b0 || add !== 18'd0 || div !== 18'd16383 || frame_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_in_latch: rv=%0b add=%0d div=%0d fc=%0d required 0 0 16383 0",
                     range_valid, add, div, frame_cnt);
        end
        @(negedge clk);
        tests_run++;
        if (range_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_latch_late: rv=%0b required 0", range_valid);
        end
    endtask

    task automatic test_last_without_valid();
        do_reset();
        send_pix(100, 1'b0);
        send_pix(300, 1'b0);
        @(negedge clk);
        din = 14'd9999; din_valid = 1'b0; din_last = 1'b1;
        @(negedge clk);
        din_last = 1'b0;
        tests_run++;
        if (din_rdy !== 1'b1 || range_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL last_no_valid: rdy=%0b rv=%0b required 1 0", din_rdy, range_valid);
        end
        @(negedge clk);
        tests_run++;
        if (range_valid !== 1'b0 || frame_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL last_no_valid_pulse: rv=%0b fc=%0d required 0 0", range_valid, frame_cnt);
        end
        send_pix(200, 1'b1);
        observe_frame_end();
        tests_run++;
        if (obs_add !== 18'd100 || obs_div !== 18'd200 || obs_fc !== 16'd1) begin
            tests_failed++;
            $display("FAIL last_no_valid_frame: add=%0d div=%0d fc=%0d required 100 200 1", obs_add, obs_div, obs_fc);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_ramp(0, 1000);
        observe_frame_end();
        tests_run++;
        if (obs_add !== 18'd0 || obs_div !== 18'd1000) begin
            tests_failed++;
            $display("FAIL b2b_frame1: add=%0d div=%0d required 0 1000", obs_add, obs_div);
        end
        send_ramp(800, 1800);
        observe_frame_end();
`ifdef HIST_RANGE_IIR_EN
        tests_run++;
        if (obs_add !== 18'd100 || obs_div !== 18'd1000 || obs_fc !== 16'd2) begin
            tests_failed++;
            $display("FAIL iir_frame2: add=%0d div=%0d fc=%0d required 100 1000 2", obs_add, obs_div, obs_fc);
        end
`else
        tests_run++;
        if (obs_add !== 18'd800 || obs_div !== 18'd1000 || obs_fc !== 16'd2) begin
            tests_failed++;
            $display("FAIL b2b_frame2: add=%0d div=%0d fc=%0d required 800 1000 2", obs_add, obs_div, obs_fc);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_flat();
        test_extremes();
        test_reset_mid_frame();
        test_reset_in_latch();
        test_last_without_valid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
